// File: rtl/vec_issue_sequencer.sv
// vec_issue_sequencer
// Accepts one vector instruction at a time from the scalar core and issues
// beats to the vector datapath.
// - Each beat covers LANE_BITS of data, so it holds
//   EPB = LANE_BITS / SEW elements.
// - A beat advances every cycle for compute ops.
// - A beat advances only on mem_ack for memory ops.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   inst_valid  instruction offered
//   inst_ready  sequencer idle, can accept
//   is_vec      decoder says legal vector op
//   is_cfg      vsetvl-class op
//   is_mem      vector load/store
//   vl          active vector length
//   sew         element width code
//   flush       abort running instruction
//   mem_ack     memory unit took the current beat
//   exec_valid  current beat valid
//   elem_idx    first element index of current beat
//   lane_en     per-element-slot enable of current beat
//   busy        state is not IDLE
//   done        one-cycle completion pulse
//   illegal     one-cycle rejection pulse
module vec_issue_sequencer #(
  parameter int VL_W      = 13,
  parameter int LANE_BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic            is_vec,
  input  logic            is_cfg,
  input  logic            is_mem,
  input  logic [VL_W-1:0] vl,
  input  logic [2:0]      sew,
  input  logic            flush,
  input  logic            mem_ack,
  output logic            exec_valid,
  output logic [VL_W-1:0] elem_idx,
  output logic [7:0]      lane_en,
  output logic            busy,
  output logic            done,
  output logic            illegal
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            is_mem_q;
  logic [VL_W-1:0] vl_q;
  logic [VL_W-1:0] epb_q;
  logic            exec_valid_q, exec_valid_d;
  logic [VL_W-1:0] elem_idx_q, elem_idx_d;
  logic [7:0]      lane_en_q, lane_en_d;
  logic            done_q, done_d;
  logic            illegal_q, illegal_d;

  // Elements per beat for a SEW code (the reserved codes never reach here).
  function automatic logic [VL_W-1:0] epb_of(input logic [1:0] code);
    case (code)
      2'd0:    epb_of = VL_W'(LANE_BITS / 8);
      2'd1:    epb_of = VL_W'(LANE_BITS / 16);
      2'd2:    epb_of = VL_W'(LANE_BITS / 32);
      default: epb_of = VL_W'(LANE_BITS / 64);
    endcase
  endfunction

  logic            accept;
  logic            bad_inst;
  logic            no_beats;
  logic [VL_W-1:0] epb_in;
  logic [VL_W-1:0] remain;
  logic [VL_W-1:0] remain_next;
  logic            last_beat;
  logic            advance;
  logic [VL_W-1:0] lane_cnt;
  logic [7:0]      lane_mask;

  assign accept      = inst_valid && (state_q == S_IDLE);
  assign bad_inst    = !is_vec || sew[2];
  assign no_beats    = is_cfg || (vl == '0);
  assign epb_in      = epb_of(sew[1:0]);
  assign remain      = vl_q - elem_idx_q;
  // Only meaningful when the current beat is not the last one.
  assign remain_next = remain - epb_q;
  assign last_beat   = (remain <= epb_q);
  assign advance     = (state_q == S_EXEC) && (!is_mem_q || mem_ack);

  // Number of enabled slots for the beat being loaded into the output
  // registers: the first beat on acceptance, otherwise the following beat.
  always_comb begin
    lane_cnt = '0;
    if (state_q == S_IDLE) begin
      lane_cnt = (vl < epb_in) ? vl : epb_in;
    end else begin
      lane_cnt = (remain_next < epb_q) ? remain_next : epb_q;
    end
  end

  // Slots at or above EPB are never enabled, because lane_cnt <= EPB.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_mask[gi] = (VL_W'(gi) < lane_cnt);
    end
  endgenerate

  // State register, plus the registered outputs and the latched instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      is_mem_q     <= 1'b0;
      vl_q         <= '0;
      epb_q        <= '0;
      exec_valid_q <= 1'b0;
      elem_idx_q   <= '0;
      lane_en_q    <= '0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      exec_valid_q <= exec_valid_d;
      elem_idx_q   <= elem_idx_d;
      lane_en_q    <= lane_en_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      if (accept) begin
        is_mem_q <= is_mem;
        vl_q     <= vl;
        epb_q    <= epb_in;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && !bad_inst) begin
          state_d = no_beats ? S_DONE : S_EXEC;
        end
      end
      S_EXEC: begin
        // Flush takes priority over completing the final beat.
        if (flush) begin
          state_d = S_IDLE;
        end else if (advance && last_beat) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    exec_valid_d = 1'b0;
    elem_idx_d   = '0;
    lane_en_d    = '0;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad_inst) begin
            illegal_d = 1'b1;
          end else if (no_beats) begin
            done_d = 1'b1;
          end else begin
            exec_valid_d = 1'b1;
            lane_en_d    = lane_mask;
          end
        end
      end
      S_EXEC: begin
        if (!flush) begin
          if (!advance) begin
            exec_valid_d = 1'b1;
            elem_idx_d   = elem_idx_q;
            lane_en_d    = lane_en_q;
          end else if (last_beat) begin
            done_d = 1'b1;
          end else begin
            exec_valid_d = 1'b1;
            elem_idx_d   = elem_idx_q + epb_q;
            lane_en_d    = lane_mask;
          end
        end
      end
      default: ;
    endcase
  end

  assign inst_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign exec_valid = exec_valid_q;
  assign elem_idx   = elem_idx_q;
  assign lane_en    = lane_en_q;
  assign done       = done_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_vec_issue_sequencer.sv
// Self-checking bench for vec_issue_sequencer.
// - Expected per-cycle output snapshots are queued as stimulus is driven.
// - Each snapshot is popped and compared 1 time unit after the clock edge.
module tb_vec_issue_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic        is_vec;
  logic        is_cfg;
  logic        is_mem;
  logic [12:0] vl;
  logic [2:0]  sew;
  logic        flush;
  logic        mem_ack;
  logic        exec_valid;
  logic [12:0] elem_idx;
  logic [7:0]  lane_en;
  logic        busy;
  logic        done;
  logic        illegal;

  vec_issue_sequencer #(.VL_W(13), .LANE_BITS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .is_vec     (is_vec),
    .is_cfg     (is_cfg),
    .is_mem     (is_mem),
    .vl         (vl),
    .sew        (sew),
    .flush      (flush),
    .mem_ack    (mem_ack),
    .exec_valid (exec_valid),
    .elem_idx   (elem_idx),
    .lane_en    (lane_en),
    .busy       (busy),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ready;
    logic        busy;
    logic        ev;
    logic        pos_chk;   // elem_idx/lane_en are defined in this cycle
    logic [12:0] idx;
    logic [7:0]  lane;
    logic        done;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t exp_idle(input logic pos);
    exp_t e;
    e = '0;
    e.ready = 1'b1;
    e.pos_chk = pos;
    return e;
  endfunction

  function automatic exp_t exp_done();
    exp_t e;
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    return e;
  endfunction

  function automatic exp_t exp_beat(input int idx, input int len, input int epb);
    exp_t e;
    int   cnt;
    e = '0;
    cnt = (len - idx < epb) ? (len - idx) : epb;
    e.busy = 1'b1;
    e.ev = 1'b1;
    e.pos_chk = 1'b1;
    e.idx = 13'(idx);
    for (int i = 0; i < 8; i++) e.lane[i] = (i < cnt);
    return e;
  endfunction

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val("inst_ready", 32'(inst_ready), 32'(e.ready));
      check_val("busy", 32'(busy), 32'(e.busy));
      check_val("exec_valid", 32'(exec_valid), 32'(e.ev));
      check_val("done", 32'(done), 32'(e.done));
      check_val("illegal", 32'(illegal), 32'(e.ill));
      if (e.pos_chk) begin
        check_val("elem_idx", 32'(elem_idx), 32'(e.idx));
        check_val("lane_en", 32'(lane_en), 32'(e.lane));
      end
    end
  endtask

  // After acceptance, input changes must not disturb the running instruction.
  task automatic scramble();
    inst_valid = 1'b0;
    is_vec = 1'($urandom);
    is_cfg = 1'($urandom);
    is_mem = 1'($urandom);
    vl = 13'($urandom);
    sew = 3'($urandom);
    flush = 1'b0;
  endtask

  // flush_at: cycle k (counted from acceptance) in which flush is held high.
  //           -1 means flush is held during the accepting IDLE cycle.
  // reset_at: cycle k in which reset is driven low.
  task automatic run_inst(input string name, input logic v, input logic c, input logic m,
                          input int len, input logic [2:0] s, input logic [31:0] ack_pat,
                          input int flush_at, input int reset_at);
    exp_t e;
    int   epb;
    int   idx;
    int   k;
    bit   stop;
    epb = 8 >> s[1:0];
    inst_valid = 1'b1;
    is_vec = v;
    is_cfg = c;
    is_mem = m;
    vl = 13'(len);
    sew = s;
    mem_ack = 1'($urandom);
    flush = (flush_at < 0);
    if (!v || s[2]) begin
      e = exp_idle(1'b0);
      e.ill = 1'b1;
      exp_q.push_back(e);
      tick();
      scramble();
      exp_q.push_back(exp_idle(1'b0));
      tick();
    end else if (c || len == 0) begin
      exp_q.push_back(exp_done());
      tick();
      scramble();
      exp_q.push_back(exp_idle(1'b0));
      tick();
    end else begin
      idx = 0;
      exp_q.push_back(exp_beat(idx, len, epb));
      tick();
      scramble();
      k = 1;
      stop = 0;
      while (!stop) begin
        mem_ack = (k <= 32) ? ack_pat[k-1] : 1'b1;
        flush = (k == flush_at);
        reset = !(k == reset_at);
        if (k == reset_at) begin
          exp_q.push_back(exp_idle(1'b1));
          stop = 1;
        end else if (k == flush_at) begin
          exp_q.push_back(exp_idle(1'b0));
          stop = 1;
        end else if (!m || mem_ack) begin
          idx += epb;
          if (idx >= len) begin
            exp_q.push_back(exp_done());
            stop = 1;
          end else begin
            exp_q.push_back(exp_beat(idx, len, epb));
          end
        end else begin
          exp_q.push_back(exp_beat(idx, len, epb));
        end
        tick();
        k++;
      end
      mem_ack = 1'b0;
      flush = 1'b0;
      reset = 1'b1;
      exp_q.push_back(exp_idle(1'b0));
      tick();
    end
    $display("txn %s vec=%0b cfg=%0b mem=%0b vl=%0d sew=%0d failures_so_far=%0d",
             name, v, c, m, len, s, n_fail);
  endtask

  initial begin
    reset = 1'b0;
    inst_valid = 1'b1;
    is_vec = 1'b1;
    is_cfg = 1'b0;
    is_mem = 1'b0;
    vl = 13'd5;
    sew = 3'd0;
    flush = 1'b0;
    mem_ack = 1'b0;
    exp_q.push_back(exp_idle(1'b1));
    tick();
    exp_q.push_back(exp_idle(1'b1));
    tick();
    inst_valid = 1'b0;
    reset = 1'b1;
    exp_q.push_back(exp_idle(1'b1));
    tick();

    run_inst("vl10_e8", 1, 0, 0, 10, 3'd0, $urandom, 0, 0);
    run_inst("mem_vl3_e32", 1, 0, 1, 3, 3'd2, 32'h0000_000C, 0, 0);
    run_inst("vl0", 1, 0, 0, 0, 3'd0, 32'h0, 0, 0);
    run_inst("cfg", 1, 1, 0, 5, 3'd1, 32'h0, 0, 0);
    run_inst("sew_rsvd", 1, 0, 0, 8, 3'd4, 32'h0, 0, 0);
    run_inst("not_vec", 0, 1, 0, 8, 3'd0, 32'h0, 0, 0);
    run_inst("flush_t5", 1, 0, 0, 64, 3'd3, $urandom, 5, 0);
    run_inst("reset_t3", 1, 0, 0, 64, 3'd3, $urandom, 0, 3);
    run_inst("flush_last", 1, 0, 0, 10, 3'd0, $urandom, 2, 0);
    run_inst("flush_idle", 1, 0, 0, 10, 3'd0, $urandom, -1, 0);
    run_inst("vl7_e16", 1, 0, 0, 7, 3'd1, $urandom, 0, 0);
    run_inst("mem_vl9_e64", 1, 0, 1, 9, 3'd3, $urandom, 0, 0);
    run_inst("vl4096_e8", 1, 0, 0, 4096, 3'd0, $urandom, 0, 0);
    for (int i = 0; i < 20; i++) begin
      run_inst("rand", 1, 0, 1'($urandom), int'($urandom_range(1, 20)),
               3'($urandom_range(0, 3)), $urandom, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_issue_sequencer.md
VEC_ISSUE_SEQUENCER -- requirements
Module: vec_issue_sequencer

Interface
REQ-001 SHALL have parameter VL_W, default 13, width of vl and element index (max vl 4096).
REQ-002 SHALL have parameter LANE_BITS, default 64, datapath bits processed per beat.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port inst_valid  input  1  scalar core offers an instruction.
REQ-006 SHALL have port inst_ready  output  1  sequencer can accept an instruction.
REQ-007 SHALL have port is_vec  input  1  decoder flag, legal vector instruction.
REQ-008 SHALL have port is_cfg  input  1  vsetvl-class configuration instruction.
REQ-009 SHALL have port is_mem  input  1  vector load/store instruction.
REQ-010 SHALL have port vl  input  VL_W  active vector length from CSR file.
REQ-011 SHALL have port sew  input  3  element width code: 000=8, 001=16, 010=32, 011=64, 1xx reserved.
REQ-012 SHALL have port flush  input  1  abort current instruction.
REQ-013 SHALL have port mem_ack  input  1  memory unit accepted current beat.
REQ-014 SHALL have port exec_valid  output  1  current beat valid to datapath.
REQ-015 SHALL have port elem_idx  output  VL_W  index of first element in current beat.
REQ-016 SHALL have port lane_en  output  8  per-element-slot enable for current beat.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-018 SHALL have port done  output  1  one-cycle completion pulse.
REQ-019 SHALL have port illegal  output  1  one-cycle pulse for rejected instruction.

Function
REQ-020 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-021 SHALL assert inst_ready only in IDLE; acceptance = inst_valid && inst_ready at a rising edge (cycle T).
REQ-022 SHALL latch is_cfg, is_mem, vl, sew on acceptance; later input changes SHALL NOT affect the running instruction.
REQ-023 On acceptance with is_vec=0 or sew=1xx SHALL pulse illegal in T+1, stay IDLE, no exec_valid, no done.
REQ-024 On acceptance with is_cfg=1 or vl=0 SHALL go to DONE (done=1 in T+1), no exec_valid.
REQ-025 Otherwise SHALL go to EXEC; elements per beat EPB = LANE_BITS/SEW bits (8,4,2,1 for default), beats = ceil(vl/EPB).
REQ-026 In EXEC, exec_valid SHALL be 1; elem_idx SHALL start at 0 and add EPB per advanced beat.
REQ-027 lane_en SHALL have low min(EPB, vl-elem_idx) bits set, others 0; slots >= EPB always 0.
REQ-028 Non-mem op SHALL advance one beat per cycle; mem op SHALL advance only in cycles with mem_ack=1, holding elem_idx/lane_en otherwise.
REQ-029 After the final beat advances SHALL enter DONE; DONE lasts exactly one cycle with done=1, then IDLE.
REQ-030 flush=1 in EXEC or DONE SHALL return to IDLE next cycle, no done pulse; flush in IDLE SHALL be ignored.
REQ-031 flush and final-beat advance in the same cycle: flush SHALL win.
REQ-032 mem_ack outside EXEC or with is_mem=0 SHALL be ignored.
REQ-033 elem_idx arithmetic SHALL be VL_W bits wide with no wrap for any vl <= 2^(VL_W-1).
REQ-034 exec_valid, lane_en, done, illegal SHALL be registered (no combinational path from inputs).

Reset
REQ-035 reset=0 at an edge SHALL force IDLE: inst_ready=1, busy=0, exec_valid=0, elem_idx=0, lane_en=0, done=0, illegal=0.
REQ-036 reset during EXEC SHALL abandon the instruction; no done pulse after reset release.

Verification
REQ-037 vl=10, sew=000, non-mem accepted at T -> T+1 elem_idx=0 lane_en=FF; T+2 elem_idx=8 lane_en=03; T+3 done=1; T+4 inst_ready=1.
REQ-038 vl=3, sew=010, is_mem, mem_ack first high at T+3 then T+4 -> beat0 (idx 0, lane_en=03) held T+1..T+3; beat1 (idx 2, lane_en=01) at T+4; done at T+5.
REQ-039 vl=0 or is_cfg=1 -> done=1 at T+1, exec_valid never 1.
REQ-040 sew=100 or is_vec=0 -> illegal=1 at T+1, inst_ready=1 at T+1, no done.
REQ-041 vl=64, sew=011, flush at T+5 -> IDLE at T+6, no done; reset=0 at T+3 of a second run -> all outputs at reset values at T+4.
